// File: rtl/digit_serial_adder_if.sv
`default_nettype none
// ============================================================================
// Module   : digit_serial_adder_if
// Purpose  : Handshake/operand bundle for the digit-serial adder.
//            master : drives start, a, b, ci; observes busy, done, s, co
//            slave  : the adder side of the same signals
// Ports    : start (request), a/b (N-bit operands), ci (carry-in),
//            busy (in RUN), done (one-cycle result pulse),
//            s (N-bit sum), co (carry-out)
// Revision : 1.0 - initial release
// ============================================================================
interface digit_serial_adder_if #(
    parameter int N = 8
);
    logic         start;
    logic [N-1:0] a;
    logic [N-1:0] b;
    logic         ci;
    logic         busy;
    logic         done;
    logic [N-1:0] s;
    logic         co;

    modport master (
        output start, a, b, ci,
        input  busy, done, s, co
    );

    modport slave (
        input  start, a, b, ci,
        output busy, done, s, co
    );
endinterface
`default_nettype wire

// File: rtl/digit_serial_adder.sv
`default_nettype none
// ============================================================================
// Module   : digit_serial_adder
// Purpose  : Adds two N-bit operands plus carry-in one 2-bit digit per clock,
//            LSB digit first, and presents {co, s} with a one-cycle done
//            pulse after N/2 digit cycles.
// Ports    : clk  - rising-edge clock
//            rst  - asynchronous active-high reset
//            bus  - digit_serial_adder_if.slave (start, a, b, ci in;
//                   busy, done, s, co out)
// Revision : 1.0 - initial release
// ============================================================================
module digit_serial_adder #(
    parameter int N = 8
) (
    input  wire logic             clk,
    input  wire logic             rst,
    digit_serial_adder_if.slave   bus
);

    localparam int c_D  = N / 2;
    localparam int c_KW = (c_D > 1) ? $clog2(c_D) : 1;

    localparam logic [1:0] c_IDLE = 2'd0;
    localparam logic [1:0] c_RUN  = 2'd1;
    localparam logic [1:0] c_DONE = 2'd2;

    logic [1:0]      r_state;
    logic [N-1:0]    r_a;
    logic [N-1:0]    r_b;
    logic            r_carry;
    logic [N-1:0]    r_psum;
    logic [c_KW-1:0] r_k;
    logic            r_busy;
    logic            r_done;
    logic [N-1:0]    r_s;
    logic            r_co;

    logic [1:0]      w_da;
    logic [1:0]      w_db;
    logic [2:0]      w_sum;
    logic [N-1:0]    w_psum_next;
    logic            w_last;

    // Digit k occupies bits [2k+1:2k]; {r_k,1'b0} is the bit offset 2k.
    always_comb begin
        w_da        = r_a[{r_k, 1'b0} +: 2];
        w_db        = r_b[{r_k, 1'b0} +: 2];
        w_sum       = 3'(w_da) + 3'(w_db) + 3'(r_carry);
        w_psum_next = r_psum;
        w_psum_next[{r_k, 1'b0} +: 2] = w_sum[1:0];
        w_last      = (r_k == c_KW'(c_D - 1));
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= c_IDLE;
            r_a     <= '0;
            r_b     <= '0;
            r_carry <= 1'b0;
            r_psum  <= '0;
            r_k     <= '0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_s     <= '0;
            r_co    <= 1'b0;
        end else begin
            case (r_state)
                c_RUN: begin
                    r_psum  <= w_psum_next;
                    r_carry <= w_sum[2];
                    r_k     <= r_k + c_KW'(1);
                    if (w_last) begin
                        // Results become visible only here, so s/co never
                        // show intermediate digits.
                        r_state <= c_DONE;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                        r_s     <= w_psum_next;
                        r_co    <= w_sum[2];
                    end
                end
                // IDLE and DONE both accept a new start; DONE falls back to
                // IDLE after its single cycle. Unused encodings recover here.
                default: begin
                    r_done <= 1'b0;
                    if (bus.start) begin
                        r_a     <= bus.a;
                        r_b     <= bus.b;
                        r_carry <= bus.ci;
                        r_k     <= '0;
                        r_psum  <= '0;
                        r_busy  <= 1'b1;
                        r_state <= c_RUN;
                    end else begin
                        r_busy  <= 1'b0;
                        r_state <= c_IDLE;
                    end
                end
            endcase
        end
    end

    assign bus.busy = r_busy;
    assign bus.done = r_done;
    assign bus.s    = r_s;
    assign bus.co   = r_co;

endmodule
`default_nettype wire

// File: tb/tb_digit_serial_adder.sv
`default_nettype none
// ============================================================================
// Module   : tb_digit_serial_adder
// Purpose  : Self-checking bench for digit_serial_adder (N = 8, D = 4).
//            Expected {co, s} values are pushed to a queue when an add is
//            started and popped when done is observed.
// Revision : 1.0 - initial release
// ============================================================================
module tb_digit_serial_adder;

    localparam int c_N = 8;

    logic clk;
    logic rst;

    digit_serial_adder_if #(.N(c_N)) bus ();

    digit_serial_adder #(.N(c_N)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int tests_run    = 0;
    int tests_failed = 0;

    logic [c_N:0] r_expq[$];

    // Drive a start request at the current (negative-edge) time and queue
    // the expected (N+1)-bit result.
    task automatic drive_start(input logic [c_N-1:0] a, input logic [c_N-1:0] b,
                               input logic ci, input bit push);
        bus.start = 1'b1;
        bus.a     = a;
        bus.b     = b;
        bus.ci    = ci;
        if (push) r_expq.push_back((c_N+1)'(a) + (c_N+1)'(b) + (c_N+1)'(ci));
    endtask

    task automatic test_reset;
        rst = 1'b1;
        bus.start = 1'b0; bus.a = '0; bus.b = '0; bus.ci = 1'b0;
        repeat (2) @(negedge clk);
        tests_run++;
        if ({bus.busy, bus.done, bus.co, bus.s} !== 11'd0) begin
            tests_failed++;
            $display("FAIL reset_state: got busy=%b done=%b co=%b s=%h, want all 0",
                     bus.busy, bus.done, bus.co, bus.s);
        end
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_zero_add;
        int cyc = 0;
        int busy_cnt = 0;
        logic [c_N:0] exp;
        drive_start(8'h00, 8'h00, 1'b0, 1'b1);
        do begin
            @(negedge clk);
            bus.start = 1'b0;
            cyc++;
            if (bus.busy) busy_cnt++;
        end while (!bus.done && cyc < 20);
        tests_run++;
        if (cyc != 5) begin
            tests_failed++;
            $display("FAIL zero_latency: done at cycle %0d, want 5", cyc);
        end
        tests_run++;
        if (busy_cnt != 4) begin
            tests_failed++;
            $display("FAIL zero_busy_cycles: got %0d, want 4", busy_cnt);
        end
        exp = r_expq.pop_front();
        tests_run++;
        if ({bus.co, bus.s} !== exp) begin
            tests_failed++;
            $display("FAIL zero_result: got %h, want %h", {bus.co, bus.s}, exp);
        end
        @(negedge clk);
        tests_run++;
        if (bus.done !== 1'b0) begin
            tests_failed++;
            $display("FAIL zero_done_pulse: done=%b one cycle later, want 0", bus.done);
        end
    endtask

    task automatic test_carry_in;
        int cyc = 0;
        logic [c_N:0] exp;
        drive_start(8'h80, 8'h01, 1'b1, 1'b1);
        do begin
            @(negedge clk);
            bus.start = 1'b0;
            bus.a = 8'hFF; bus.b = 8'hFF; bus.ci = 1'b0;  // must not matter
            cyc++;
        end while (!bus.done && cyc < 20);
        tests_run++;
        if (cyc != 5) begin
            tests_failed++;
            $display("FAIL carry_in_latency: done at cycle %0d, want 5", cyc);
        end
        exp = r_expq.pop_front();
        tests_run++;
        if ({bus.co, bus.s} !== exp || exp !== 9'h082) begin
            tests_failed++;
            $display("FAIL carry_in_result: got %h, want %h", {bus.co, bus.s}, exp);
        end
        @(negedge clk);
    endtask

    task automatic test_back_to_back;
        int cyc = 0;
        logic [c_N:0] exp;
        drive_start(8'h80, 8'h80, 1'b0, 1'b1);
        do begin
            @(negedge clk);
            bus.start = 1'b0;
            cyc++;
        end while (!bus.done && cyc < 20);
        exp = r_expq.pop_front();
        tests_run++;
        if (!bus.done || {bus.co, bus.s} !== exp) begin
            tests_failed++;
            $display("FAIL overflow_result: got done=%b %h, want done=1 %h",
                     bus.done, {bus.co, bus.s}, exp);
        end
        // Start held high in the DONE cycle.
        drive_start(8'hFF, 8'h00, 1'b1, 1'b1);
        cyc = 0;
        do begin
            @(negedge clk);
            bus.start = 1'b0;
            cyc++;
        end while (!bus.done && cyc < 20);
        tests_run++;
        if (cyc != 5) begin
            tests_failed++;
            $display("FAIL b2b_spacing: second done %0d cycles after first, want 5", cyc);
        end
        exp = r_expq.pop_front();
        tests_run++;
        if ({bus.co, bus.s} !== exp) begin
            tests_failed++;
            $display("FAIL b2b_ripple_result: got %h, want %h", {bus.co, bus.s}, exp);
        end
        @(negedge clk);
    endtask

    task automatic test_busy_protection;
        int cyc = 0;
        int extra = 0;
        logic [c_N:0] exp;
        drive_start(8'h12, 8'h34, 1'b0, 1'b1);
        @(negedge clk); bus.start = 1'b0;
        @(negedge clk);
        drive_start(8'hFF, 8'hFF, 1'b0, 1'b0);  // ignored while busy
        cyc = 2;
        do begin
            @(negedge clk);
            bus.start = 1'b0;
            cyc++;
        end while (!bus.done && cyc < 20);
        exp = r_expq.pop_front();
        tests_run++;
        if (!bus.done || {bus.co, bus.s} !== exp) begin
            tests_failed++;
            $display("FAIL busy_protect_result: got done=%b %h, want done=1 %h",
                     bus.done, {bus.co, bus.s}, exp);
        end
        repeat (8) begin
            @(negedge clk);
            if (bus.done || bus.busy) extra++;
        end
        tests_run++;
        if (extra != 0) begin
            tests_failed++;
            $display("FAIL busy_protect_no_rerun: %0d active cycles after done, want 0", extra);
        end
    endtask

    task automatic test_reset_mid_op;
        int cyc = 0;
        int spurious = 0;
        logic [c_N:0] exp;
        drive_start(8'hAA, 8'h55, 1'b1, 1'b0);  // will be abandoned
        @(negedge clk); bus.start = 1'b0;       // RUN cycle 1
        @(negedge clk);                         // RUN cycle 2
        rst = 1'b1;
        #1;
        tests_run++;
        if ({bus.busy, bus.done, bus.co, bus.s} !== 11'd0) begin
            tests_failed++;
            $display("FAIL reset_mid_op_outputs: got busy=%b done=%b co=%b s=%h, want all 0",
                     bus.busy, bus.done, bus.co, bus.s);
        end
        @(negedge clk);
        rst = 1'b0;
        repeat (8) begin
            @(negedge clk);
            if (bus.done || bus.busy) spurious++;
        end
        tests_run++;
        if (spurious != 0) begin
            tests_failed++;
            $display("FAIL reset_mid_op_no_done: %0d active cycles, want 0", spurious);
        end
        drive_start(8'h0F, 8'h01, 1'b0, 1'b1);
        do begin
            @(negedge clk);
            bus.start = 1'b0;
            cyc++;
        end while (!bus.done && cyc < 20);
        exp = r_expq.pop_front();
        tests_run++;
        if (!bus.done || {bus.co, bus.s} !== exp) begin
            tests_failed++;
            $display("FAIL after_reset_result: got done=%b %h, want done=1 %h",
                     bus.done, {bus.co, bus.s}, exp);
        end
        @(negedge clk);
    endtask

    task automatic test_hold;
        int bad = 0;
        for (int i = 0; i < 10; i++) begin
            bus.start = 1'b0;
            bus.a  = 8'($urandom);
            bus.b  = 8'($urandom);
            bus.ci = 1'($urandom);
            @(negedge clk);
            if (bus.s !== 8'h10 || bus.co !== 1'b0 || bus.done !== 1'b0) bad++;
        end
        tests_run++;
        if (bad != 0) begin
            tests_failed++;
            $display("FAIL hold: %0d cycles deviated from s=10 co=0 done=0 (last s=%h co=%b done=%b)",
                     bad, bus.s, bus.co, bus.done);
        end
    endtask

    task automatic test_random;
        logic [c_N:0] exp;
        for (int i = 0; i < 8; i++) begin
            int cyc = 0;
            drive_start(8'($urandom), 8'($urandom), 1'($urandom), 1'b1);
            do begin
                @(negedge clk);
                bus.start = 1'b0;
                cyc++;
            end while (!bus.done && cyc < 20);
            tests_run++;
            if (!bus.done || r_expq.size() == 0) begin
                tests_failed++;
                $display("FAIL random_%0d_timeout: no done within %0d cycles", i, cyc);
                r_expq.delete();
            end else begin
                exp = r_expq.pop_front();
                if ({bus.co, bus.s} !== exp) begin
                    tests_failed++;
                    $display("FAIL random_%0d_result: got %h, want %h", i, {bus.co, bus.s}, exp);
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_zero_add();
        test_carry_in();
        test_back_to_back();
        test_busy_protection();
        test_reset_mid_op();
        test_hold();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
`default_nettype wire
